skein1024_ubi_driver: RTL and testbench

- Sequences one Skein-1024 hash through the Threefish-1024 block pipeline; this block is the initiator side of the pipeline's state/key/tweak/valid interface.
- Accepts message blocks over a valid/ready handshake and builds the UBI key (chaining value plus parity word) and tweak (position, type, first/final flags).
- Issues each block to the pipeline, waits for its result, applies the UBI feed-forward XOR, then runs the output UBI stage.
- Presents the 1024-bit digest over a valid/ready handshake.

---
 rtl/skein_pkg.sv | 49 ++++
 rtl/skein1024_key_prep.sv | 52 +++++
 rtl/skein1024_ubi_driver.sv | 181 ++++++++++++++++++
 tb/tb_skein1024_ubi_driver.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/skein_pkg.sv
// Shared constants, state encoding and helper functions for the Skein-1024
// UBI driver.
//   SKEIN_C240        : key-schedule parity constant
//   T_MSG / T_OUT     : UBI type codes for message and output stages
//   TW_*              : bit positions inside the 128-bit tweak {t1, t0}
//   skein_tweak()     : builds the 192-bit tweak bus {t0^t1, t1, t0}
//   skein_key()       : builds the 1088-bit extended key {parity, chain}
package skein_pkg;

    localparam logic [63:0] SKEIN_C240  = 64'h1BD11BDAA9FC1A22;
    localparam logic [5:0]  T_MSG       = 6'd48;
    localparam logic [5:0]  T_OUT       = 6'd63;
    localparam int          TW_TYPE_LSB = 120;
    localparam int          TW_FIRST    = 126;
    localparam int          TW_FINAL    = 127;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_OISSUE,
        S_OWAIT,
        S_DONE
    } drv_state_t;

    // pos occupies bits 95:0; bits 119:96 stay zero.
    function automatic logic [191:0] skein_tweak(input logic [95:0] pos,
                                                 input logic [5:0]  typ,
                                                 input logic        first,
                                                 input logic        fin);
        logic [127:0] tw;
        tw                  = '0;
        tw[95:0]            = pos;
        tw[TW_TYPE_LSB +: 6] = typ;
        tw[TW_FIRST]        = first;
        tw[TW_FINAL]        = fin;
        return {tw[127:64] ^ tw[63:0], tw};
    endfunction

    function automatic logic [1087:0] skein_key(input logic [1023:0] chain);
        logic [63:0] par;
        par = SKEIN_C240;
        for (int i = 0; i < 16; i++) begin
            par = par ^ chain[64*i +: 64];
        end
        return {par, chain};
    endfunction

endpackage

// File: rtl/skein1024_key_prep.sv
// Registered key/tweak preparation stage in front of the Threefish pipeline.
// The 17-word parity XOR and tweak packing happen here so the driver FSM only
// has to present raw chain/pos/flags one cycle before the issue.
//   clk, rst_n      : clock, asynchronous active-low reset
//   load            : capture inputs; core_valid pulses the following cycle
//   blk, chain, pos, typ, first, fin : block and UBI parameters to issue
//   core_state/core_key/core_type/core_valid : pipeline input bus (registered)
module skein1024_key_prep (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [1023:0] blk,
    input  logic [1023:0] chain,
    input  logic [95:0]   pos,
    input  logic [5:0]    typ,
    input  logic          first,
    input  logic          fin,
    output logic [1023:0] core_state,
    output logic [1087:0] core_key,
    output logic [191:0]  core_type,
    output logic          core_valid
);
    import skein_pkg::*;

    logic [1023:0] r_state;
    logic [1087:0] r_key;
    logic [191:0]  r_type;
    logic          r_valid;

    // Data buses only load on an issue, so they stay stable until the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= '0;
            r_key   <= '0;
            r_type  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= load;
            if (load) begin
                r_state <= blk;
                r_key   <= skein_key(chain);
                r_type  <= skein_tweak(pos, typ, first, fin);
            end
        end
    end

    assign core_state = r_state;
    assign core_key   = r_key;
    assign core_type  = r_type;
    assign core_valid = r_valid;

endmodule

// File: rtl/skein1024_ubi_driver.sv
// Skein-1024 UBI sequencer: accepts message blocks, issues each to the
// Threefish-1024 pipeline with its key/tweak, applies the feed-forward XOR,
// then runs the output UBI stage and presents the digest.
//   clk, rst_n                       : clock, asynchronous active-low reset
//   iv                               : initial chaining value, taken on first block
//   msg_valid/msg_ready/msg_data/msg_bytes/msg_last : message block input
//   core_state/core_key/core_type/core_valid        : pipeline issue bus
//   core_out/core_out_valid          : pipeline result
//   hash_data/hash_valid/hash_ready  : digest output
//   busy                             : high whenever not IDLE
module skein1024_ubi_driver (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1023:0] iv,
    input  logic          msg_valid,
    output logic          msg_ready,
    input  logic [1023:0] msg_data,
    input  logic [7:0]    msg_bytes,
    input  logic          msg_last,
    output logic [1023:0] core_state,
    output logic [1087:0] core_key,
    output logic [191:0]  core_type,
    output logic          core_valid,
    input  logic [1023:0] core_out,
    input  logic          core_out_valid,
    output logic [1023:0] hash_data,
    output logic          hash_valid,
    input  logic          hash_ready,
    output logic          busy
);
    import skein_pkg::*;

    drv_state_t    r_state, w_next;
    logic [95:0]   r_pos;
    logic          r_first;
    logic          r_last;
    logic [1023:0] r_block;
    logic [1023:0] r_chain;
    logic [1023:0] r_hash;

    logic [7:0]    w_bytes_sat;
    logic [1023:0] w_masked;
    logic [95:0]   w_pos_next;
    logic [1023:0] w_chain_src;
    logic [1023:0] w_chain_new;
    logic          w_msg_ready;
    logic          w_msg_hs;
    logic          w_kp_load;
    logic [1023:0] w_kp_blk;
    logic [1023:0] w_kp_chain;
    logic [95:0]   w_kp_pos;
    logic [5:0]    w_kp_typ;
    logic          w_kp_first;
    logic          w_kp_fin;

    assign w_bytes_sat = (msg_bytes > 8'd128) ? 8'd128 : msg_bytes;
    assign w_pos_next  = r_pos + {88'd0, w_bytes_sat};
    assign w_chain_src = r_first ? iv : r_chain;
    assign w_chain_new = core_out ^ r_block;

    // Bytes at or beyond the valid count are zeroed before hashing.
    always_comb begin
        w_masked = '0;
        for (int i = 0; i < 128; i++) begin
            w_masked[8*i +: 8] = (8'(i) < w_bytes_sat) ? msg_data[8*i +: 8] : 8'h00;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Key-prep inputs are presented one cycle ahead so core_valid lands on
    // the cycle the FSM sits in ISSUE/OISSUE.
    always_comb begin
        w_next      = r_state;
        w_msg_ready = 1'b0;
        w_msg_hs    = 1'b0;
        w_kp_load   = 1'b0;
        w_kp_blk    = w_masked;
        w_kp_chain  = w_chain_src;
        w_kp_pos    = w_pos_next;
        w_kp_typ    = T_MSG;
        w_kp_first  = r_first;
        w_kp_fin    = msg_last;
        case (r_state)
            S_IDLE: begin
                w_msg_ready = rst_n;
                w_msg_hs    = msg_valid & rst_n;
                if (w_msg_hs) begin
                    w_kp_load = 1'b1;
                    w_next    = S_ISSUE;
                end
            end
            S_ISSUE:  w_next = S_WAIT;
            S_WAIT: begin
                if (core_out_valid) begin
                    if (r_last) begin
                        w_kp_load  = 1'b1;
                        w_kp_blk   = '0;
                        w_kp_chain = w_chain_new;
                        w_kp_pos   = 96'd8;
                        w_kp_typ   = T_OUT;
                        w_kp_first = 1'b1;
                        w_kp_fin   = 1'b1;
                        w_next     = S_OISSUE;
                    end else begin
                        w_next = S_IDLE;
                    end
                end
            end
            S_OISSUE: w_next = S_OWAIT;
            S_OWAIT:  if (core_out_valid) w_next = S_DONE;
            S_DONE:   if (hash_ready) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // core_out_valid is only honoured in WAIT/OWAIT; stray results from an
    // unreset pipeline fall through the other cases.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pos   <= '0;
            r_first <= 1'b1;
            r_last  <= 1'b0;
            r_block <= '0;
            r_chain <= '0;
            r_hash  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_msg_hs) begin
                        r_block <= w_masked;
                        r_pos   <= w_pos_next;
                        r_last  <= msg_last;
                        r_chain <= w_chain_src;
                    end
                end
                S_WAIT: begin
                    if (core_out_valid) begin
                        r_chain <= w_chain_new;
                        r_first <= 1'b0;
                    end
                end
                S_OWAIT: begin
                    if (core_out_valid) r_hash <= core_out;
                end
                S_DONE: begin
                    if (hash_ready) begin
                        r_pos   <= '0;
                        r_first <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    skein1024_key_prep u_key_prep (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (w_kp_load),
        .blk        (w_kp_blk),
        .chain      (w_kp_chain),
        .pos        (w_kp_pos),
        .typ        (w_kp_typ),
        .first      (w_kp_first),
        .fin        (w_kp_fin),
        .core_state (core_state),
        .core_key   (core_key),
        .core_type  (core_type),
        .core_valid (core_valid)
    );

    assign msg_ready  = w_msg_ready;
    assign hash_data  = r_hash;
    assign hash_valid = (r_state == S_DONE);
    assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_skein1024_ubi_driver.sv
// Scoreboard bench for skein1024_ubi_driver. A behavioural stand-in for the
// Threefish pipeline (fixed latency, simple keyed mixing function) produces
// results; a reference UBI model built on the same mixing function predicts
// every issue and digest, and a monitor compares them as the DUT presents them.
module tb_skein1024_ubi_driver;

    localparam int CORE_LATENCY = 121;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1023:0] iv;
    logic          msg_valid;
    logic          msg_ready;
    logic [1023:0] msg_data;
    logic [7:0]    msg_bytes;
    logic          msg_last;
    logic [1023:0] core_state;
    logic [1087:0] core_key;
    logic [191:0]  core_type;
    logic          core_valid;
    logic [1023:0] core_out;
    logic          core_out_valid;
    logic [1023:0] hash_data;
    logic          hash_valid;
    logic          hash_ready;
    logic          busy;

    always #5 clk = ~clk;

    skein1024_ubi_driver dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .iv             (iv),
        .msg_valid      (msg_valid),
        .msg_ready      (msg_ready),
        .msg_data       (msg_data),
        .msg_bytes      (msg_bytes),
        .msg_last       (msg_last),
        .core_state     (core_state),
        .core_key       (core_key),
        .core_type      (core_type),
        .core_valid     (core_valid),
        .core_out       (core_out),
        .core_out_valid (core_out_valid),
        .hash_data      (hash_data),
        .hash_valid     (hash_valid),
        .hash_ready     (hash_ready),
        .busy           (busy)
    );

    typedef struct {
        logic [1023:0] st;
        logic [1087:0] key;
        logic [191:0]  tw;
    } issue_t;

    typedef struct {
        int            due;
        logic [1023:0] d;
    } core_t;

    issue_t        iss_q[$];
    logic [1023:0] hash_q[$];
    core_t         core_q[$];

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    logic stray_req = 1'b0;

    // Stimulus table with hand-derived tweak words.
    logic [1023:0] blk_data  [8];
    int            blk_bytes [8];
    logic          blk_last  [8];
    logic [63:0]   blk_t0    [8];
    logic [63:0]   blk_t1    [8];
    logic [1023:0] iv1, iv2;

    task automatic check_bits(input string name, input logic [1087:0] act, input logic [1087:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (low 128 bits shown)", name, act[127:0], exp[127:0]);
        end
    endtask

    function automatic logic [1023:0] f_mask(input logic [1023:0] d, input int n);
        logic [1023:0] m;
        int lim;
        lim = (n > 128) ? 128 : n;
        for (int b = 0; b < 1024; b++) m[b] = ((b / 8) < lim) ? d[b] : 1'b0;
        return m;
    endfunction

    function automatic logic [1087:0] f_key(input logic [1023:0] ch);
        logic [63:0] p;
        p = 64'h1BD11BDAA9FC1A22;
        for (int w = 0; w < 16; w++) p = p ^ ch[64*w +: 64];
        return {p, ch};
    endfunction

    function automatic logic [1023:0] f_core(input logic [1023:0] st, input logic [1087:0] k, input logic [191:0] tw);
        return {st[1016:0], st[1023:1017]} ^ k[1023:0]
             ^ {16{k[1087:1024] + 64'h9E3779B97F4A7C15}}
             ^ {8{tw[127:0]}} ^ {16{tw[191:128]}};
    endfunction

    // Pipeline stand-in: sees issues on the falling edge, returns results
    // CORE_LATENCY cycles later; never reset.
    initial begin
        core_t c;
        core_out_valid = 1'b0;
        core_out       = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (core_valid === 1'b1) begin
                c.due = cyc + CORE_LATENCY;
                c.d   = f_core(core_state, core_key, core_type);
                core_q.push_back(c);
            end
            core_out_valid = 1'b0;
            if (core_q.size() > 0 && core_q[0].due == cyc) begin
                core_out_valid = 1'b1;
                core_out       = core_q[0].d;
                void'(core_q.pop_front());
            end else if (stray_req) begin
                core_out_valid = 1'b1;
                core_out       = {32{32'hDEADBEEF}};
                stray_req      = 1'b0;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT issues or hands off a digest.
    always @(negedge clk) begin
        issue_t e;
        logic [1023:0] h;
        if (core_valid === 1'b1) begin
            if (iss_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL issue_unexpected: got type %h expected no issue", core_type);
            end else begin
                e = iss_q.pop_front();
                check_bits("issue_state", core_state, e.st);
                check_bits("issue_key",   core_key,   e.key);
                check_bits("issue_tweak", core_type,  e.tw);
            end
            check_bits("ready_low_on_issue", {msg_ready, busy}, 2'b01);
        end
        if (hash_valid === 1'b1 && hash_ready === 1'b1) begin
            if (hash_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL hash_unexpected: got %h expected no digest", hash_data[127:0]);
            end else begin
                h = hash_q.pop_front();
                check_bits("digest", hash_data, h);
            end
        end
    end

    task automatic model_hash(input logic [1023:0] ivv, input int first, input int cnt, input bit full);
        logic [1023:0] ch, st;
        logic [1087:0] k;
        logic [191:0]  tw;
        issue_t it;
        ch = ivv;
        for (int i = first; i < first + cnt; i++) begin
            st = f_mask(blk_data[i], blk_bytes[i]);
            tw = {blk_t0[i] ^ blk_t1[i], blk_t1[i], blk_t0[i]};
            k  = f_key(ch);
            it.st = st; it.key = k; it.tw = tw;
            iss_q.push_back(it);
            ch = f_core(st, k, tw) ^ st;
        end
        if (full) begin
            k  = f_key(ch);
            tw = {64'd8 ^ 64'hFF00000000000000, 64'hFF00000000000000, 64'd8};
            it.st = '0; it.key = k; it.tw = tw;
            iss_q.push_back(it);
            hash_q.push_back(f_core('0, k, tw));
        end
    endtask

    task automatic send_block(input int idx, input bit pre_stray);
        int n;
        if (pre_stray) begin
            n = 0;
            while (msg_ready !== 1'b1 && n < 1000) begin @(posedge clk); #1; n++; end
            stray_req = 1'b1;
            repeat (3) begin @(posedge clk); #1; end
        end
        msg_valid = 1'b1;
        msg_data  = blk_data[idx];
        msg_bytes = 8'(blk_bytes[idx]);
        msg_last  = blk_last[idx];
        n = 0;
        while (msg_ready !== 1'b1 && n < 1000) begin @(posedge clk); #1; n++; end
        if (msg_ready !== 1'b1) begin
            checks++; errors++;
            $display("FAIL msg_ready_timeout: got 0 expected 1 within 1000 cycles (block %0d)", idx);
            msg_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        msg_valid = 1'b0;
        check_bits("issue_latency", core_valid, 1'b1);
    endtask

    task automatic finish_hash(input int hold, input bit stray, input bit simul, input int nidx);
        int n;
        bit stable;
        logic [1023:0] v;
        n = 0;
        while (hash_valid !== 1'b1 && n < 2000) begin @(posedge clk); #1; n++; end
        if (hash_valid !== 1'b1) begin
            checks++; errors++;
            $display("FAIL hash_valid_timeout: got 0 expected 1 within 2000 cycles");
            return;
        end
        v = hash_data;
        if (stray) stray_req = 1'b1;
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (hash_valid !== 1'b1 || hash_data !== v) stable = 1'b0;
        end
        if (hold > 0) check_bits("hash_hold_stable", stable, 1'b1);
        hash_ready = 1'b1;
        if (simul) begin
            msg_valid = 1'b1;
            msg_data  = blk_data[nidx];
            msg_bytes = 8'(blk_bytes[nidx]);
            msg_last  = blk_last[nidx];
        end
        @(posedge clk); #1;
        hash_ready = 1'b0;
        if (simul) check_bits("simul_hash_first", {hash_valid, msg_ready, core_valid}, 3'b010);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish before 2000000 time units");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int w = 0; w < 16; w++) begin
            iv1[64*w +: 64] = 64'h0F0E0D0C0B0A0908 + 64'(w) * 64'h1111111111111111;
            iv2[64*w +: 64] = 64'hA0B1C2D3E4F50617 ^ (64'(w) << 8);
        end
        blk_data[0] = {16{64'h0123456789ABCDEF}}; blk_bytes[0] = 0;   blk_last[0] = 1'b1;
        blk_t0[0] = 64'd0;   blk_t1[0] = 64'hF000000000000000;
        blk_data[1] = {1024{1'b1}};               blk_bytes[1] = 1;   blk_last[1] = 1'b1;
        blk_t0[1] = 64'd1;   blk_t1[1] = 64'hF000000000000000;
        blk_data[2] = {16{64'hA5A55A5AC3C33C3C}}; blk_bytes[2] = 128; blk_last[2] = 1'b0;
        blk_t0[2] = 64'd128; blk_t1[2] = 64'h7000000000000000;
        blk_data[3] = {16{64'h3C3C5A5A96966969}}; blk_bytes[3] = 128; blk_last[3] = 1'b0;
        blk_t0[3] = 64'd256; blk_t1[3] = 64'h3000000000000000;
        blk_data[4] = {16{64'h0F1E2D3C4B5A6978}}; blk_bytes[4] = 64;  blk_last[4] = 1'b1;
        blk_t0[4] = 64'd320; blk_t1[4] = 64'hB000000000000000;
        blk_data[5] = {16{64'hCAFEBABE12345678}}; blk_bytes[5] = 200; blk_last[5] = 1'b1;
        blk_t0[5] = 64'd128; blk_t1[5] = 64'hF000000000000000;
        blk_data[6] = '0;                         blk_bytes[6] = 0;   blk_last[6] = 1'b1;
        blk_t0[6] = 64'd0;   blk_t1[6] = 64'hF000000000000000;
        blk_data[7] = '0;                         blk_bytes[7] = 0;   blk_last[7] = 1'b1;
        blk_t0[7] = 64'd0;   blk_t1[7] = 64'hF000000000000000;

        rst_n = 1'b0; iv = iv1; msg_valid = 1'b0; msg_data = '0; msg_bytes = 8'd0;
        msg_last = 1'b0; hash_ready = 1'b0;
        #1;
        check_bits("reset_ctrl", {msg_ready, core_valid, hash_valid, busy}, 4'b0000);
        check_bits("reset_buses", {core_state, core_type, hash_data} != '0, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check_bits("ready_after_reset", {msg_ready, busy}, 2'b10);

        // Empty message, stray result in DONE, digest held 50 cycles.
        model_hash(iv1, 0, 1, 1);
        send_block(0, 1'b0);
        finish_hash(50, 1'b1, 1'b0, 0);

        // Single 0xFF byte; next hash's first block arrives with hash_ready.
        model_hash(iv1, 1, 1, 1);
        send_block(1, 1'b0);
        check_bits("ff_state", core_state, 1024'hFF);
        model_hash(iv2, 2, 3, 1);
        iv = iv2;
        finish_hash(3, 1'b0, 1'b1, 2);

        // Three-block message, stray result in IDLE between blocks.
        send_block(2, 1'b0);
        send_block(3, 1'b1);
        send_block(4, 1'b0);
        finish_hash(0, 1'b0, 1'b0, 0);

        // msg_bytes above 128 saturates.
        model_hash(iv1, 5, 1, 1);
        iv = iv1;
        send_block(5, 1'b0);
        finish_hash(0, 1'b0, 1'b0, 0);

        // Reset while waiting on the pipeline; stale result must be ignored.
        iv = iv2;
        model_hash(iv2, 6, 1, 1'b0);
        send_block(6, 1'b0);
        repeat (10) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        check_bits("midreset_ctrl", {msg_ready, core_valid, hash_valid, busy}, 4'b0000);
        check_bits("midreset_buses", {core_state, core_key, core_type, hash_data} != '0, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        n = 0;
        while (core_q.size() != 0 && n < 500) begin @(posedge clk); #1; n++; end
        check_bits("stale_drained", core_q.size() == 0, 1'b1);
        repeat (3) begin @(posedge clk); #1; end
        check_bits("stale_ignored", {msg_ready, busy, hash_valid}, 3'b100);

        model_hash(iv2, 7, 1, 1);
        send_block(7, 1'b0);
        finish_hash(0, 1'b0, 1'b0, 0);

        repeat (5) begin @(posedge clk); #1; end
        check_bits("queues_empty", {iss_q.size() == 0, hash_q.size() == 0}, 2'b11);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
